// File: rtl/soc_obi2apb.sv
// OBI (64-bit data, 48-bit address) to APB (32-bit) bridge: one OBI transaction at a time,
// split into one or two APB beats by byte enables, with an optional per-beat watchdog.

package soc_bus_pkg;
    localparam int unsigned ObiAddrW = 48;
    localparam int unsigned ObiDataW = 64;
    localparam int unsigned ObiBeW   = 8;
    localparam int unsigned ObiIdW   = 4;
    localparam int unsigned ApbAddrW = 32;
    localparam int unsigned ApbDataW = 32;
    localparam int unsigned ApbStrbW = 4;

    typedef struct packed {
        logic [ObiAddrW-1:0] addr;
        logic                we;
        logic [ObiBeW-1:0]   be;
        logic [ObiDataW-1:0] wdata;
        logic [ObiIdW-1:0]   aid;
    } soc_obi_a_t;

    typedef struct packed {
        logic       req;
        soc_obi_a_t a;
    } soc_obi_req_t;

    typedef struct packed {
        logic [ObiDataW-1:0] rdata;
        logic [ObiIdW-1:0]   rid;
        logic                err;
    } soc_obi_r_t;

    typedef struct packed {
        logic       gnt;
        logic       rvalid;
        soc_obi_r_t r;
    } soc_obi_rsp_t;

    typedef struct packed {
        logic [ApbAddrW-1:0] paddr;
        logic [2:0]          pprot;
        logic                psel;
        logic                penable;
        logic                pwrite;
        logic [ApbDataW-1:0] pwdata;
        logic [ApbStrbW-1:0] pstrb;
    } soc_apb_req_t;

    typedef struct packed {
        logic                pready;
        logic [ApbDataW-1:0] prdata;
        logic                pslverr;
    } soc_apb_resp_t;
endpackage

module soc_obi2apb
    import soc_bus_pkg::*;
#(
    parameter logic [2:0]  PProt         = 3'b000,
    parameter bit          ErrOnHighAddr = 1'b1,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  soc_obi_req_t  obi_req_i,
    output soc_obi_rsp_t  obi_rsp_o,
    output soc_apb_req_t  apb_req_o,
    input  soc_apb_resp_t apb_rsp_i
);
    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state;
    logic [28:0]         addr_q;
    logic                we_q;
    logic [3:0]          be_hi_q;
    logic [31:0]         wdata_hi_q;
    logic [ObiIdW-1:0]   aid_q;
    logic                half_q;
    logic                last_q;
    logic [63:0]         rdata_q;
    logic                err_q;
    logic [CntW-1:0]     cnt_q;

    logic                rvalid_q;
    logic [63:0]         rsp_rdata_q;
    logic [ObiIdW-1:0]   rsp_rid_q;
    logic                rsp_err_q;
    logic                psel_q;
    logic                penable_q;
    logic [31:0]         paddr_q;
    logic                pwrite_q;
    logic [31:0]         pwdata_q;
    logic [3:0]          pstrb_q;

    logic                gnt_c;
    logic                lo_c;
    logic                hi_c;
    logic                high_addr_c;
    logic                wd_fire_c;
    logic [63:0]         rdata_merge_c;
    logic                err_merge_c;
    logic                unused_c;

    assign gnt_c       = (state == IDLE) && obi_req_i.req;
    // be == 0 still performs one lower-half access with a zero strobe
    assign lo_c        = (obi_req_i.a.be[3:0] != 4'h0) || (obi_req_i.a.be == 8'h00);
    assign hi_c        = (obi_req_i.a.be[7:4] != 4'h0);
    assign high_addr_c = ErrOnHighAddr && (obi_req_i.a.addr[47:32] != 16'h0000);
    assign wd_fire_c   = (TimeoutCycles != 0) && (cnt_q == CntW'(TimeoutCycles - 1));
    assign err_merge_c = err_q | apb_rsp_i.pslverr;
    assign unused_c    = ^obi_req_i.a.addr[2:0];

    // Read data as it will look once the current beat's prdata is folded in
    always_comb begin
        rdata_merge_c = rdata_q;
        if (!we_q) begin
            if (half_q) rdata_merge_c[63:32] = apb_rsp_i.prdata;
            else        rdata_merge_c[31:0]  = apb_rsp_i.prdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_hi_q     <= '0;
            wdata_hi_q  <= '0;
            aid_q       <= '0;
            half_q      <= 1'b0;
            last_q      <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            rvalid_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_rid_q   <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_c) begin
                        addr_q     <= obi_req_i.a.addr[31:3];
                        we_q       <= obi_req_i.a.we;
                        be_hi_q    <= obi_req_i.a.be[7:4];
                        wdata_hi_q <= obi_req_i.a.wdata[63:32];
                        aid_q      <= obi_req_i.a.aid;
                        rdata_q    <= '0;
                        cnt_q      <= '0;
                        half_q     <= !lo_c;
                        last_q     <= !(lo_c && hi_c);
                        err_q      <= high_addr_c;
                        if (high_addr_c) begin
                            state     <= RESP;
                            rvalid_q  <= 1'b1;
                            rsp_rid_q <= obi_req_i.a.aid;
                            rsp_err_q <= 1'b1;
                        end else begin
                            state     <= SETUP;
                            psel_q    <= 1'b1;
                            penable_q <= 1'b0;
                            paddr_q   <= {obi_req_i.a.addr[31:3], !lo_c, 2'b00};
                            pwrite_q  <= obi_req_i.a.we;
                            pwdata_q  <= lo_c ? obi_req_i.a.wdata[31:0] : obi_req_i.a.wdata[63:32];
                            pstrb_q   <= !obi_req_i.a.we ? 4'h0 :
                                         (lo_c ? obi_req_i.a.be[3:0] : obi_req_i.a.be[7:4]);
                        end
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                end
                ACCESS: begin
                    // A pready in the timeout cycle takes priority over the abort
                    if (apb_rsp_i.pready) begin
                        rdata_q <= rdata_merge_c;
                        err_q   <= err_merge_c;
                        if (apb_rsp_i.pslverr || last_q) begin
                            state       <= RESP;
                            rvalid_q    <= 1'b1;
                            rsp_rdata_q <= rdata_merge_c;
                            rsp_rid_q   <= aid_q;
                            rsp_err_q   <= err_merge_c;
                            psel_q      <= 1'b0;
                            penable_q   <= 1'b0;
                            paddr_q     <= '0;
                            pwrite_q    <= 1'b0;
                            pwdata_q    <= '0;
                            pstrb_q     <= '0;
                        end else begin
                            state     <= SETUP;
                            half_q    <= 1'b1;
                            last_q    <= 1'b1;
                            penable_q <= 1'b0;
                            paddr_q   <= {addr_q, 1'b1, 2'b00};
                            pwdata_q  <= wdata_hi_q;
                            pstrb_q   <= we_q ? be_hi_q : 4'h0;
                        end
                    end else if (wd_fire_c) begin
                        state       <= RESP;
                        err_q       <= 1'b1;
                        rvalid_q    <= 1'b1;
                        rsp_rdata_q <= rdata_q;
                        rsp_rid_q   <= aid_q;
                        rsp_err_q   <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        paddr_q     <= '0;
                        pwrite_q    <= 1'b0;
                        pwdata_q    <= '0;
                        pstrb_q     <= '0;
                    end else if (TimeoutCycles != 0) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    rvalid_q    <= 1'b0;
                    rsp_rdata_q <= '0;
                    rsp_rid_q   <= '0;
                    rsp_err_q   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign obi_rsp_o.gnt     = gnt_c;
    assign obi_rsp_o.rvalid  = rvalid_q;
    assign obi_rsp_o.r.rdata = rsp_rdata_q;
    assign obi_rsp_o.r.rid   = rsp_rid_q;
    assign obi_rsp_o.r.err   = rsp_err_q;

    assign apb_req_o.paddr   = paddr_q;
    assign apb_req_o.pprot   = PProt;
    assign apb_req_o.psel    = psel_q;
    assign apb_req_o.penable = penable_q;
    assign apb_req_o.pwrite  = pwrite_q;
    assign apb_req_o.pwdata  = pwdata_q;
    assign apb_req_o.pstrb   = pstrb_q;
endmodule

// File: tb/tb_soc_obi2apb.sv
// Bench for soc_obi2apb: directed table, reset-abort sequence and random transactions
// checked against a transaction-level model of the bridge.

module tb_soc_obi2apb;
    import soc_bus_pkg::*;

    localparam int Tmo = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    soc_obi_req_t  obi_req;
    soc_obi_rsp_t  obi_rsp;
    soc_apb_req_t  apb_req;
    soc_apb_resp_t apb_rsp;
    int            cyc = 0;
    int            n_vec = 0;
    int            n_bad = 0;

    soc_obi2apb #(.PProt(3'b000), .ErrOnHighAddr(1'b1), .TimeoutCycles(Tmo)) dut (
        .clk_i(clk), .rst_i(rst), .obi_req_i(obi_req), .obi_rsp_o(obi_rsp),
        .apb_req_o(apb_req), .apb_rsp_i(apb_rsp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               lat;
        logic [63:0]      rdata;
        logic             err;
        logic [3:0]       rid;
        int               ntx;
        logic [1:0][31:0] paddr;
        logic [1:0]       pwrite;
        logic [1:0][31:0] pwdata;
        logic [1:0][3:0]  pstrb;
        logic             rv_once;
        int               hold_bad;
    } res_t;

    typedef struct {
        logic [47:0] addr;
        logic        we;
        logic [7:0]  be;
        logic [63:0] wdata;
        logic [3:0]  aid;
        int          w0, w1;
        logic        e0, e1;
        logic [31:0] d0, d1;
        int          lat;
        logic [63:0] rdata;
        logic        err;
        int          ntx;
        logic [31:0] paddr0;
        logic [3:0]  pstrb0;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: walk the beat list, each beat costs one SETUP plus its ACCESS cycles
    function automatic void model(input vec_t v, output res_t e);
        int halves[$];
        int w, acc;
        logic ek;
        logic [31:0] d;
        e = '{default: 0};
        e.rid = v.aid;
        e.lat = 1;
        if (v.addr[47:32] != 16'h0) begin
            e.err = 1'b1;
            return;
        end
        if (v.be[3:0] != 4'h0 || v.be == 8'h00) halves.push_back(0);
        if (v.be[7:4] != 4'h0) halves.push_back(1);
        foreach (halves[i]) begin
            int h = halves[i];
            w  = (h == 1) ? v.w1 : v.w0;
            ek = (h == 1) ? v.e1 : v.e0;
            d  = (h == 1) ? v.d1 : v.d0;
            e.paddr[i]  = {v.addr[31:3], h[0], 2'b00};
            e.pwrite[i] = v.we;
            e.pwdata[i] = v.wdata[h*32 +: 32];
            e.pstrb[i]  = v.we ? v.be[h*4 +: 4] : 4'h0;
            e.ntx++;
            if (w >= Tmo) begin
                e.err = 1'b1;
                e.lat += 1 + Tmo;
                return;
            end
            acc = w + 1;
            e.lat += 1 + acc;
            if (!v.we) e.rdata[h*32 +: 32] = d;
            if (ek) begin
                e.err = 1'b1;
                return;
            end
        end
    endfunction

    // Drives one OBI request and plays an APB completer with per-half wait states
    task automatic run_txn(input vec_t v, input string tag, output res_t o);
        int t0, acc, k;
        logic got;
        o = '{default: 0};
        o.lat = -1;
        @(negedge clk);
        obi_req.req     = 1'b1;
        obi_req.a.addr  = v.addr;
        obi_req.a.we    = v.we;
        obi_req.a.be    = v.be;
        obi_req.a.wdata = v.wdata;
        obi_req.a.aid   = v.aid;
        #1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (obi_rsp.gnt) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk({tag, "_gnt"}, 64'(got), 64'd1);
        t0 = cyc;
        acc = 0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            obi_req.req = 1'b0;
            apb_rsp = '0;
            if (obi_rsp.rvalid) begin
                o.lat   = cyc - t0;
                o.rdata = obi_rsp.r.rdata;
                o.rid   = obi_rsp.r.rid;
                o.err   = obi_rsp.r.err;
                if (apb_req.psel) o.hold_bad++;
                break;
            end
            if (apb_req.psel && !apb_req.penable) begin
                if (o.ntx < 2) begin
                    o.paddr[o.ntx]  = apb_req.paddr;
                    o.pwrite[o.ntx] = apb_req.pwrite;
                    o.pwdata[o.ntx] = apb_req.pwdata;
                    o.pstrb[o.ntx]  = apb_req.pstrb;
                end
                o.ntx++;
                acc = 0;
            end else if (apb_req.psel && apb_req.penable) begin
                if (o.ntx == 0 || o.ntx > 2 || apb_req.paddr != o.paddr[o.ntx-1] ||
                    apb_req.pwdata != o.pwdata[o.ntx-1] || apb_req.pstrb != o.pstrb[o.ntx-1])
                    o.hold_bad++;
                if (acc == (apb_req.paddr[2] ? v.w1 : v.w0)) begin
                    apb_rsp.pready  = 1'b1;
                    apb_rsp.prdata  = apb_req.paddr[2] ? v.d1 : v.d0;
                    apb_rsp.pslverr = apb_req.paddr[2] ? v.e1 : v.e0;
                end
                acc++;
            end
        end
        chk({tag, "_rvalid_seen"}, 64'(k < 200), 64'd1);
        @(negedge clk);
        apb_rsp = '0;
        o.rv_once = !obi_rsp.rvalid && !apb_req.psel;
    endtask

    task automatic compare(input string tag, input res_t o, input res_t e);
        chk({tag, "_lat"},   64'(o.lat),   64'(e.lat));
        chk({tag, "_rdata"}, o.rdata,      e.rdata);
        chk({tag, "_rid"},   64'(o.rid),   64'(e.rid));
        chk({tag, "_err"},   64'(o.err),   64'(e.err));
        chk({tag, "_ntx"},   64'(o.ntx),   64'(e.ntx));
        chk({tag, "_rv_once"}, 64'(o.rv_once), 64'd1);
        chk({tag, "_hold"},  64'(o.hold_bad), 64'd0);
        for (int i = 0; i < 2; i++) begin
            if (i < e.ntx && i < o.ntx) begin
                chk($sformatf("%s_paddr%0d", tag, i),  64'(o.paddr[i]),  64'(e.paddr[i]));
                chk($sformatf("%s_pwrite%0d", tag, i), 64'(o.pwrite[i]), 64'(e.pwrite[i]));
                chk($sformatf("%s_pwdata%0d", tag, i), 64'(o.pwdata[i]), 64'(e.pwdata[i]));
                chk($sformatf("%s_pstrb%0d", tag, i),  64'(o.pstrb[i]),  64'(e.pstrb[i]));
            end
        end
    endtask

    initial begin
        res_t o, e;
        vec_t v;
        int nrv;
        logic got;

        //            addr                we    be     wdata                   aid   w0   w1  e0 e1  d0            d1            lat rdata                   err ntx paddr0        pstrb0
        tbl[0]  = '{48'h0000_1000_0010, 1'b1, 8'h0F, 64'hAAAA_BBBB_1111_2222, 4'd3, 0,   0,  0, 0, 32'h0,        32'h0,        3, 64'h0,                  0, 1, 32'h1000_0010, 4'hF};
        tbl[1]  = '{48'h0000_2000_0008, 1'b0, 8'hFF, 64'h0,                   4'd5, 2,   2,  0, 0, 32'h1234_5678, 32'h9ABC_DEF0, 9, 64'h9ABC_DEF0_1234_5678, 0, 2, 32'h2000_0008, 4'h0};
        tbl[2]  = '{48'h0000_0000_0100, 1'b1, 8'hC0, 64'h5555_6666_7777_8888, 4'd1, 0,   0,  0, 0, 32'h0,        32'h0,        3, 64'h0,                  0, 1, 32'h0000_0104, 4'hC};
        tbl[3]  = '{48'h0000_3000_0000, 1'b0, 8'hFF, 64'h0,                   4'd2, 0,   0,  1, 0, 32'hDEAD_BEEF, 32'h7777_7777, 3, 64'h0000_0000_DEAD_BEEF, 1, 1, 32'h3000_0000, 4'h0};
        tbl[4]  = '{48'h0001_0000_0000, 1'b0, 8'hFF, 64'h0,                   4'd7, 0,   0,  0, 0, 32'h0,        32'h0,        1, 64'h0,                  1, 0, 32'h0,         4'h0};
        tbl[5]  = '{48'h0000_4000_0000, 1'b0, 8'h0F, 64'h0,                   4'd4, 100, 0,  0, 0, 32'h5555_5555, 32'h0,        6, 64'h0,                  1, 1, 32'h4000_0000, 4'h0};
        tbl[6]  = '{48'h0000_4000_0004, 1'b0, 8'hF0, 64'h0,                   4'd6, 0,   1,  0, 0, 32'h0,        32'hCAFE_F00D, 4, 64'hCAFE_F00D_0000_0000, 0, 1, 32'h4000_0004, 4'h0};
        tbl[7]  = '{48'h0000_0000_0050, 1'b1, 8'h00, 64'h1234_5678_9ABC_DEF0, 4'd8, 0,   0,  0, 0, 32'h0,        32'h0,        3, 64'h0,                  0, 1, 32'h0000_0050, 4'h0};
        tbl[8]  = '{48'h0000_0000_0200, 1'b0, 8'h0F, 64'h0,                   4'd9, 3,   0,  0, 0, 32'h0BAD_CAFE, 32'h0,        6, 64'h0000_0000_0BAD_CAFE, 0, 1, 32'h0000_0200, 4'h0};
        tbl[9]  = '{48'h0000_0000_0300, 1'b0, 8'hFF, 64'h0,                   4'hA, 0,   100, 0, 0, 32'h1111_2222, 32'h3333_4444, 8, 64'h0000_0000_1111_2222, 1, 2, 32'h0000_0300, 4'h0};
        tbl[10] = '{48'h0000_0000_0400, 1'b0, 8'hFF, 64'h0,                   4'hB, 1,   0,  0, 1, 32'hAAAA_0001, 32'hBBBB_0002, 6, 64'hBBBB_0002_AAAA_0001, 1, 2, 32'h0000_0400, 4'h0};
        tbl[11] = '{48'h0000_0000_0060, 1'b1, 8'h3C, 64'hFEDC_BA98_7654_3210, 4'hC, 0,   0,  0, 0, 32'h0,        32'h0,        5, 64'h0,                  0, 2, 32'h0000_0060, 4'hC};

        obi_req = '0;
        apb_rsp = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt",     64'(obi_rsp.gnt),     64'd0);
        chk("rst_rvalid",  64'(obi_rsp.rvalid),  64'd0);
        chk("rst_rdata",   obi_rsp.r.rdata,      64'd0);
        chk("rst_rid_err", 64'({obi_rsp.r.rid, obi_rsp.r.err}), 64'd0);
        chk("rst_psel",    64'({apb_req.psel, apb_req.penable, apb_req.pwrite}), 64'd0);
        chk("rst_paddr",   64'(apb_req.paddr),   64'd0);
        chk("rst_pwdata",  64'({apb_req.pwdata, apb_req.pstrb}), 64'd0);
        chk("rst_pprot",   64'(apb_req.pprot),   64'd0);

        for (int i = 0; i < 12; i++) begin
            string tag = $sformatf("vec%0d", i);
            run_txn(tbl[i], tag, o);
            chk({tag, "_t_lat"},   64'(o.lat), 64'(tbl[i].lat));
            chk({tag, "_t_rdata"}, o.rdata,    tbl[i].rdata);
            chk({tag, "_t_err"},   64'(o.err), 64'(tbl[i].err));
            chk({tag, "_t_rid"},   64'(o.rid), 64'(tbl[i].aid));
            chk({tag, "_t_ntx"},   64'(o.ntx), 64'(tbl[i].ntx));
            if (tbl[i].ntx > 0) begin
                chk({tag, "_t_paddr0"}, 64'(o.paddr[0]), 64'(tbl[i].paddr0));
                chk({tag, "_t_pstrb0"}, 64'(o.pstrb[0]), 64'(tbl[i].pstrb0));
            end
            model(tbl[i], e);
            compare(tag, o, e);
        end

        // Reset in the middle of an APB access: no response, bus idles, bridge usable afterwards
        @(negedge clk);
        obi_req.req   = 1'b1;
        obi_req.a     = '0;
        obi_req.a.addr = 48'h0000_7000_0000;
        obi_req.a.be  = 8'hFF;
        obi_req.a.aid = 4'h5;
        #1;
        got = obi_rsp.gnt;
        chk("rstmid_gnt", 64'(got), 64'd1);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            obi_req.req = 1'b0;
            if (apb_req.psel && apb_req.penable) begin
                got = 1'b1;
                break;
            end
        end
        chk("rstmid_access", 64'(got), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_apb", 64'({apb_req.psel, apb_req.penable, apb_req.paddr, apb_req.pstrb}), 64'd0);
        chk("rstmid_rsp", 64'({obi_rsp.rvalid, obi_rsp.r.err, obi_rsp.r.rid}), 64'd0);
        nrv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (obi_rsp.rvalid || apb_req.psel) nrv++;
        end
        chk("rstmid_quiet", 64'(nrv), 64'd0);

        for (int i = 0; i < 40; i++) begin
            string tag = $sformatf("rnd%0d", i);
            v = tbl[0];
            v.addr  = {(($urandom_range(0, 7) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0), 32'($urandom)};
            v.we    = 1'($urandom);
            v.be    = 8'($urandom);
            v.wdata = {32'($urandom), 32'($urandom)};
            v.aid   = 4'($urandom);
            v.w0    = $urandom_range(0, 5);
            v.w1    = $urandom_range(0, 5);
            v.e0    = ($urandom_range(0, 7) == 0);
            v.e1    = ($urandom_range(0, 7) == 0);
            v.d0    = 32'($urandom);
            v.d1    = 32'($urandom);
            run_txn(v, tag, o);
            model(v, e);
            compare(tag, o, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/soc_obi2apb.md
# soc_obi2apb

OBI-to-APB bridge on the SoC peripheral path, using the `soc_bus_pkg` types: a subordinate on the 64-bit, 48-bit-address OBI bus and the requester on the 32-bit APB bus. It accepts one OBI transaction at a time and splits it into one or two 32-bit APB transfers according to the byte enables. It then returns a single OBI response carrying the assembled read data, the error status and the original ID. An optional watchdog aborts a transfer when a completer never asserts `pready`.

## Interface
- `PProt`, 3'b000: constant value driven on `pprot`.
- `ErrOnHighAddr`, 1: if 1, a request with `addr[47:32] != 0` gets an error response and causes no APB access.
- `TimeoutCycles`, 255: maximum number of ACCESS cycles per APB transfer before abort; 0 disables the watchdog.
- Port `clk_i`, input, 1: the only clock.
- Port `rst_i`, input, 1: reset, synchronous and active-high.
- Port `obi_req_i`, input, `soc_obi_req_t`: carries `req`, `a.addr`, `a.we`, `a.be`, `a.wdata` and `a.aid`.
- Port `obi_rsp_o`, output, `soc_obi_rsp_t`: carries `gnt`, `rvalid`, `r.rdata`, `r.rid` and `r.err`.
- Port `apb_req_o`, output, `soc_apb_req_t`: carries `paddr`, `pprot`, `psel`, `penable`, `pwrite`, `pwdata` and `pstrb`.
- Port `apb_rsp_i`, input, `soc_apb_resp_t`: carries `pready`, `prdata` and `pslverr`.

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - `gnt = req` (combinational); `gnt` is 0 in every other state.
  - On `req & gnt`, capture `addr`, `we`, `be`, `wdata` and `aid`, and clear `rdata_q` and `err_q`.
  - Beat list: lower half if `be[3:0] != 0`, upper half if `be[7:4] != 0`.
  - If `be == 0`, perform a single lower-half access with `pstrb = 0`.
  - If `ErrOnHighAddr` and `addr[47:32] != 0`: set `err_q`, skip APB and go to RESP. Otherwise go to SETUP for the first beat.
- **SETUP**
  - `psel = 1`, `penable = 0`.
  - `paddr = {addr[31:3], half, 2'b00}`, where `half` is 0 for the lower beat and 1 for the upper beat.
  - `pwrite = we`.
  - `pwdata` = selected 32-bit half of `wdata`.
  - `pstrb` = matching `be` nibble; forced to 0 when `we = 0`.
  - Next state is always ACCESS.
- **ACCESS**
  - `psel = 1`, `penable = 1`; all other APB outputs hold their SETUP values.
  - On `pready`:
    - For reads, store `prdata` into the matching 32-bit half of `rdata_q`.
    - `err_q |= pslverr`.
    - If `pslverr = 1` or this is the last beat, go to RESP. Otherwise go to SETUP for the upper beat.
    - The remaining beat is abandoned on error.
  - Watchdog:
    - The counter resets to 0 on entry to ACCESS and increments each ACCESS cycle without `pready`.
    - When it reaches `TimeoutCycles` (non-zero): set `err_q`, deassert `psel`, and go to RESP.
- **RESP**
  - `rvalid = 1` for exactly one cycle, with `rdata = rdata_q`, `rid = aid_q` and `err = err_q`.
  - Halves that were never read return 0; write responses return `rdata = 0`.
  - Next state is IDLE.
- Only one transaction is outstanding; OBI `rready` is not used (the response is never backpressured).

## Timing
- Reset values (the same in all non-active states):
  - `gnt = 0`, `rvalid = 0`, `rdata = 0`, `rid = 0`, `err = 0`.
  - `psel = 0`, `penable = 0`, `paddr = 0`, `pwrite = 0`, `pwdata = 0`, `pstrb = 0`.
  - `pprot = PProt`.
  - State is IDLE.
- Cycle sequence, with T the grant cycle:
  - T+1 SETUP, T+2 ACCESS.
  - With zero-wait `pready`: single beat → `rvalid` at T+3; two beats → SETUP at T+3, ACCESS at T+4, `rvalid` at T+5.
  - Each wait cycle adds 1.
  - High-address error: `rvalid` at T+1.
  - Next grant is possible at the earliest one cycle after `rvalid`.
- The watchdog aborts in the cycle where the count equals `TimeoutCycles`. `rvalid` follows one cycle later, and `psel` is 0 from that cycle on.
- `pready` arriving in the same cycle as the timeout wins: the transfer completes normally.
- Reset asserted mid-transaction:
  - All outputs return to their reset values on the next edge.
  - No `rvalid` is issued for the aborted transaction.
  - A mid-transfer APB access is dropped without `penable` completion.

## Test plan
- **Lower-word write:** `addr=0x0000_1000_0010`, `we=1`, `be=0x0F`, `wdata=0xAAAA_BBBB_1111_2222`, `aid=3`, zero-wait APB. Require one APB write with `paddr=0x1000_0010`, `pwdata=0x1111_2222`, `pstrb=0xF`, then `rvalid` at T+3 with `rid=3` and `err=0`.
- **Full 64-bit read:** `be=0xFF`, `addr=0x0000_2000_0008`. Completer returns `0x1234_5678` at `paddr 0x2000_0008` and `0x9ABC_DEF0` at `0x2000_000C`, with 2 wait states on each beat. Require `rdata=0x9ABC_DEF0_1234_5678` with `rvalid` at T+9.
- **Upper-only write:** `be=0xC0`, `addr=0x0000_0000_0100`. Require exactly one APB transfer with `paddr=0x0000_0104` and `pstrb=0xC`.
- **Slave error on lower beat:** `be=0xFF` read with `pslverr=1` on the lower beat. Require no upper-half SETUP, `rvalid` with `err=1`, and `rdata=0` in the upper half.
- **High address:** `addr=0x0001_0000_0000`. Require no `psel` assertion and `rvalid` at T+1 with `err=1`.
- **Watchdog:** `TimeoutCycles=4` and `pready` held at 0. Require `psel` low after 4 ACCESS cycles and `rvalid` with `err=1`. Then run a second request and require it to be granted and to complete normally.
